// File: rtl/instruction_fetch_if.sv
// Decode-side handshake of the fetch front-end.
//
// Handshake: the fetch stage (master) raises instr_valid while it holds an
// instruction at the buffer head. instr and instr_pc stay stable while
// instr_valid is high and decode_ready is low. A transfer happens on a rising
// clock edge where instr_valid and decode_ready are both high. The one
// exception is a jump cycle: the fetch stage flushes at that edge, and the
// head it shows during that cycle is not consumed.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               decode_ready;

  modport master (
    output instr,
    output instr_pc,
    output instr_valid,
    input  decode_ready
  );

  modport slave (
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output decode_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch front-end. It issues reads to a 1-cycle synchronous ROM at
// pc_count and advances the PC through increment. Returned words are buffered
// together with their fetch address in a DEPTH-entry FIFO. A jump flushes
// both the buffered entries and the in-flight read.
module instruction_fetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic [ADDR_W-1:0]   pc_count,
  output logic                increment,
  input  logic                jump_set,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  instruction_fetch_if.master dec
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_C = (OCC_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [INSTR_W-1:0] mem_instr_d [DEPTH];
  logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
  logic [ADDR_W-1:0]  mem_pc_d    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               infl_q, infl_d;
  logic [ADDR_W-1:0]  infl_pc_q, infl_pc_d;

  logic               valid;
  logic               pop_raw;
  logic               pop;
  logic               push;
  logic [OCC_W:0]     pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) return '0;
    else             return p + PTR_W'(1);
  endfunction

  assign rom_addr = pc_count;
  assign valid    = (occ_q != '0);
  assign pop_raw  = valid & dec.decode_ready;
  // A jump edge discards the head, so it is not counted as consumed.
  assign pop      = pop_raw & ~jump_set;
  assign push     = infl_q;

  // Entries already committed (buffered plus in flight) after this cycle's
  // pop. A new read is issued only if that still leaves a free slot.
  always_comb begin
    pending   = {1'b0, occ_q} + {{OCC_W{1'b0}}, infl_q} - {{OCC_W{1'b0}}, pop_raw};
    increment = reset & fetch_en & ~jump_set & (pending < DEPTH_C);
  end

  // Head of the buffer. It reads as zero whenever the buffer is empty.
  always_comb begin
    dec.instr_valid = valid;
    dec.instr       = valid ? mem_instr_q[rd_ptr_q] : '0;
    dec.instr_pc    = valid ? mem_pc_q[rd_ptr_q]    : '0;
  end

  // Next state: a jump flushes everything, otherwise push/pop and issue.
  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    infl_d      = infl_q;
    infl_pc_d   = infl_pc_q;
    if (jump_set) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      infl_d   = 1'b0;
    end else begin
      infl_d = increment;
      if (increment) infl_pc_d = pc_count;
      if (push) begin
        mem_instr_d[wr_ptr_q] = rom_data;
        mem_pc_d[wr_ptr_q]    = infl_pc_q;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
    end
  end

endmodule
